// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ariane_pkg
// Purpose  : Shared types for the mul/div arbiter: FU request record, tag-table
//            entry and op classification helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ariane_pkg;

    localparam int XLEN                = 32;
    localparam int TRANS_ID_BITS       = 2;
    localparam int MULDIV_NR_REQ       = 2;
    localparam int MULDIV_REQ_IDX_BITS = 4;

    typedef enum logic [4:0] {
        ADD, MUL, MULH, MULHU, MULHSU, MULW,
        DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
    } fu_op;

    typedef struct packed {
        fu_op                     operator;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    typedef struct packed {
        logic                           valid;
        logic [MULDIV_REQ_IDX_BITS-1:0] requester;
        logic [TRANS_ID_BITS-1:0]       orig_trans_id;
    } muldiv_tag_t;

    function automatic logic is_mul_op(input fu_op op);
        return op inside {MUL, MULH, MULHU, MULHSU, MULW};
    endfunction

    function automatic logic is_div_op(input fu_op op);
        return op inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_res_fifo
// Purpose  : Per-requester result buffer with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_res_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_arbiter
// Purpose  : Round-robin sharing of one mul/div unit between NR_REQ requesters,
//            with tag renaming and per-requester result buffering.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_arbiter
    import ariane_pkg::*;
#(
    parameter int NR_REQ    = MULDIV_NR_REQ,
    parameter int RES_DEPTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic     [NR_REQ-1:0]                req_valid_i,
    input  fu_data_t [NR_REQ-1:0]                req_data_i,
    output logic     [NR_REQ-1:0]                req_ready_o,
    output logic     [NR_REQ-1:0]                res_valid_o,
    input  logic     [NR_REQ-1:0]                res_ready_i,
    output logic     [NR_REQ-1:0][XLEN-1:0]      res_o,
    output logic     [NR_REQ-1:0][TRANS_ID_BITS-1:0] res_trans_id_o,
    output fu_data_t                             unit_data_o,
    output logic                                 unit_valid_o,
    input  logic                                 unit_ready_i,
    output logic                                 unit_flush_o,
    input  logic     [XLEN-1:0]                  unit_result_i,
    input  logic                                 unit_valid_i,
    input  logic     [TRANS_ID_BITS-1:0]         unit_trans_id_i
);

    localparam int c_NR_TAGS  = 2 ** TRANS_ID_BITS;
    localparam int c_CREDIT_W = $clog2(RES_DEPTH + 1);
    localparam int c_PTR_W    = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int c_RES_W    = XLEN + TRANS_ID_BITS;

    muldiv_tag_t             r_tags   [c_NR_TAGS];
    logic [c_CREDIT_W-1:0]   r_credit [NR_REQ];
    logic [c_PTR_W-1:0]      r_rr_ptr;

    logic                     w_tag_avail;
    logic [TRANS_ID_BITS-1:0] w_free_tag;
    logic [NR_REQ-1:0]        w_pop;
    logic [NR_REQ-1:0]        w_elig;
    logic [NR_REQ-1:0]        w_push;
    logic                     w_found;
    logic [c_PTR_W-1:0]       w_winner;
    logic [c_PTR_W-1:0]       w_idx;
    logic                     w_ret_ok;
    muldiv_tag_t              w_ret_tag;

    // Reset also flushes the unit so nothing stale returns afterwards.
    assign unit_flush_o = flush_i | rst_i;

    always_comb begin
        w_tag_avail = 1'b0;
        w_free_tag  = '0;
        for (int t = c_NR_TAGS - 1; t >= 0; t--) begin
            if (!r_tags[t].valid) begin
                w_tag_avail = 1'b1;
                w_free_tag  = TRANS_ID_BITS'(t);
            end
        end
    end

    // A pop this cycle frees a credit, so a full requester may issue at once.
    always_comb begin
        w_pop  = '0;
        w_elig = '0;
        for (int r = 0; r < NR_REQ; r++) begin
            w_pop[r]  = res_valid_o[r] & res_ready_i[r];
            w_elig[r] = req_valid_i[r] && w_tag_avail
                     && ((int'(r_credit[r]) - int'(w_pop[r])) < RES_DEPTH)
                     && (!is_div_op(req_data_i[r].operator) || unit_ready_i);
        end
    end

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = r_rr_ptr;
        for (int k = 0; k < NR_REQ; k++) begin
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
            w_idx = (w_idx == c_PTR_W'(NR_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
        if (unit_flush_o) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (w_found) begin
            req_ready_o[w_winner] = 1'b1;
        end
    end

    always_comb begin
        unit_data_o          = req_data_i[w_winner];
        unit_data_o.trans_id = w_free_tag;
    end

    assign unit_valid_o = w_found;

    assign w_ret_tag = r_tags[unit_trans_id_i];
    assign w_ret_ok  = unit_valid_i && !unit_flush_o && w_ret_tag.valid;

    always_comb begin
        w_push = '0;
        for (int r = 0; r < NR_REQ; r++) begin
            w_push[r] = w_ret_ok && (w_ret_tag.requester == MULDIV_REQ_IDX_BITS'(r));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_winner == c_PTR_W'(NR_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    // A returning tag is never free this cycle, so clear and set cannot collide.
    always_ff @(posedge clk_i) begin
        if (unit_flush_o) begin
            for (int t = 0; t < c_NR_TAGS; t++) begin
                r_tags[t] <= '0;
            end
        end else begin
            if (w_ret_ok) begin
                r_tags[unit_trans_id_i].valid <= 1'b0;
            end
            if (w_found) begin
                r_tags[w_free_tag] <= '{valid:         1'b1,
                                        requester:     MULDIV_REQ_IDX_BITS'(w_winner),
                                        orig_trans_id: req_data_i[w_winner].trans_id};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NR_REQ; r++) begin
            if (unit_flush_o) begin
                r_credit[r] <= '0;
            end else if (req_ready_o[r] && !w_pop[r]) begin
                r_credit[r] <= r_credit[r] + 1'b1;
            end else if (!req_ready_o[r] && w_pop[r]) begin
                r_credit[r] <= r_credit[r] - 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NR_REQ; r++) begin : g_res_fifo
        logic [c_RES_W-1:0] w_head;

        muldiv_res_fifo #(
            .DEPTH (RES_DEPTH),
            .WIDTH (c_RES_W)
        ) u_fifo (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_clear (flush_i),
            .i_push  (w_push[r]),
            .i_data  ({unit_result_i, w_ret_tag.orig_trans_id}),
            .i_pop   (w_pop[r]),
            .o_valid (res_valid_o[r]),
            .o_data  (w_head)
        );

        assign res_o[r]          = w_head[c_RES_W-1:TRANS_ID_BITS];
        assign res_trans_id_o[r] = w_head[TRANS_ID_BITS-1:0];
    end

    a_ret_tag_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        (unit_valid_i && !flush_i) |-> w_ret_tag.valid)
        else $error("muldiv_arbiter: result for unallocated tag %0d", unit_trans_id_i);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_arbiter
// Purpose  : Directed bench for muldiv_arbiter with a 2-cycle multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_arbiter;
    import ariane_pkg::*;

    logic                          clk_i = 1'b0;
    logic                          rst_i = 1'b1;
    logic                          flush_i = 1'b0;
    logic     [1:0]                req_valid_i = '0;
    fu_data_t [1:0]                req_data_i = '0;
    logic     [1:0]                req_ready_o;
    logic     [1:0]                res_valid_o;
    logic     [1:0]                res_ready_i = 2'b11;
    logic     [1:0][XLEN-1:0]      res_o;
    logic     [1:0][TRANS_ID_BITS-1:0] res_trans_id_o;
    fu_data_t                      unit_data_o;
    logic                          unit_valid_o;
    logic                          unit_ready_i = 1'b1;
    logic                          unit_flush_o;
    logic     [XLEN-1:0]           unit_result_i;
    logic                          unit_valid_i;
    logic     [TRANS_ID_BITS-1:0]  unit_trans_id_i;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_arbiter #(.NR_REQ(2), .RES_DEPTH(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_o           (res_o),
        .res_trans_id_o  (res_trans_id_o),
        .unit_data_o     (unit_data_o),
        .unit_valid_o    (unit_valid_o),
        .unit_ready_i    (unit_ready_i),
        .unit_flush_o    (unit_flush_o),
        .unit_result_i   (unit_result_i),
        .unit_valid_i    (unit_valid_i),
        .unit_trans_id_i (unit_trans_id_i)
    );

    always #5 clk_i = ~clk_i;

    // Unit model: multiplies return two cycles after issue; divides are driven by hand.
    logic        m1_v = 1'b0, m2_v = 1'b0;
    logic [1:0]  m1_t = '0, m2_t = '0;
    logic [31:0] m1_r = '0, m2_r = '0;
    logic        d_v = 1'b0;
    logic [1:0]  d_t = '0;
    logic [31:0] d_r = '0;

    always @(posedge clk_i) begin
        if (unit_flush_o) begin
            m1_v <= 1'b0;
            m2_v <= 1'b0;
        end else begin
            m1_v <= unit_valid_o && !is_div_op(unit_data_o.operator);
            m2_v <= m1_v;
        end
        m1_t <= unit_data_o.trans_id;
        m1_r <= unit_data_o.operand_a * unit_data_o.operand_b;
        m2_t <= m1_t;
        m2_r <= m1_r;
    end

    assign unit_valid_i    = m2_v | d_v;
    assign unit_trans_id_i = d_v ? d_t : m2_t;
    assign unit_result_i   = d_v ? d_r : m2_r;

    typedef struct {
        logic [1:0]  valid;
        fu_op        op0;
        fu_op        op1;
        logic        uready;
        logic        flush;
        logic [1:0]  exp_ready;
        logic        exp_uvalid;
        logic [31:0] exp_opa;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string name, input int r, input logic [31:0] val,
                           input logic [1:0] tid);
        chk({name, " valid"}, 64'(res_valid_o[r]), 64'd1);
        chk({name, " data"}, 64'(res_o[r]), 64'(val));
        chk({name, " tid"}, 64'(res_trans_id_o[r]), 64'(tid));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int r, input fu_op op, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] tid);
        req_data_i[r] = '{operator: op, operand_a: a, operand_b: b, trans_id: tid};
    endtask

    task automatic idle();
        req_valid_i  = '0;
        flush_i      = 1'b0;
        res_ready_i  = 2'b11;
        unit_ready_i = 1'b1;
        d_v          = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b00, MUL,  MUL,    1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[1] = '{2'b01, MUL,  MUL,    1'b1, 1'b0, 2'b01, 1'b1, 32'h11};
        vecs[2] = '{2'b10, MUL,  MULW,   1'b1, 1'b0, 2'b10, 1'b1, 32'h22};
        vecs[3] = '{2'b11, MULH, MULHU,  1'b1, 1'b0, 2'b01, 1'b1, 32'h11};
        vecs[4] = '{2'b01, DIV,  MUL,    1'b0, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[5] = '{2'b11, DIVU, MULHSU, 1'b0, 1'b0, 2'b10, 1'b1, 32'h22};
        vecs[6] = '{2'b01, REMW, MUL,    1'b1, 1'b0, 2'b01, 1'b1, 32'h11};
        vecs[7] = '{2'b11, MUL,  MUL,    1'b1, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[8] = '{2'b10, MUL,  REMUW,  1'b0, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[9] = '{2'b11, DIVW, REM,    1'b0, 1'b0, 2'b00, 1'b0, 32'h0};

        do_reset();
        chk("reset res_valid", 64'(res_valid_o), 64'd0);
        chk("reset res_o", 64'(res_o), 64'd0);
        chk("reset unit_valid", 64'(unit_valid_o), 64'd0);
        chk("reset unit_flush", 64'(unit_flush_o), 64'd0);
        chk("reset req_ready", 64'(req_ready_o), 64'd0);

        // Single-cycle arbitration decisions from a clean state.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            set_req(0, vecs[i].op0, 32'h11, 32'h2, 2'd3);
            set_req(1, vecs[i].op1, 32'h22, 32'h3, 2'd2);
            req_valid_i  = vecs[i].valid;
            unit_ready_i = vecs[i].uready;
            flush_i      = vecs[i].flush;
            #1;
            chk($sformatf("vec%0d ready", i), 64'(req_ready_o), 64'(vecs[i].exp_ready));
            chk($sformatf("vec%0d uvalid", i), 64'(unit_valid_o), 64'(vecs[i].exp_uvalid));
            chk($sformatf("vec%0d uflush", i), 64'(unit_flush_o), 64'(vecs[i].flush));
            if (vecs[i].exp_uvalid) begin
                chk($sformatf("vec%0d tag", i), 64'(unit_data_o.trans_id), 64'd0);
                chk($sformatf("vec%0d opa", i), 64'(unit_data_o.operand_a), 64'(vecs[i].exp_opa));
            end
            step();
            idle();
        end

        // Two simultaneous MULs: round robin, consecutive tags, results at +3.
        do_reset();
        set_req(0, MUL, 32'd3, 32'd7, 2'd2);
        set_req(1, MUL, 32'd5, 32'd6, 2'd3);
        req_valid_i = 2'b11;
        #1;
        chk("A c0 ready", 64'(req_ready_o), 64'b01);
        chk("A c0 tag", 64'(unit_data_o.trans_id), 64'd0);
        step();
        req_valid_i = 2'b10;
        #1;
        chk("A c1 ready", 64'(req_ready_o), 64'b10);
        chk("A c1 tag", 64'(unit_data_o.trans_id), 64'd1);
        chk("A c1 opa", 64'(unit_data_o.operand_a), 64'd5);
        step();
        req_valid_i = 2'b00;
        #1;
        chk("A c2 res_valid", 64'(res_valid_o), 64'b00);
        step();
        chk("A c3 res_valid", 64'(res_valid_o), 64'b01);
        chk_res("A c3 req0", 0, 32'd21, 2'd2);
        step();
        chk("A c4 res_valid", 64'(res_valid_o), 64'b10);
        chk_res("A c4 req1", 1, 32'd30, 2'd3);
        step();
        chk("A c5 res_valid", 64'(res_valid_o), 64'b00);

        // DIV blocked by unit_ready_i while MUL proceeds; freed tag not reused same cycle.
        do_reset();
        unit_ready_i = 1'b0;
        set_req(0, DIV, 32'd100, 32'd5, 2'd1);
        set_req(1, MUL, 32'd9, 32'd9, 2'd0);
        req_valid_i = 2'b11;
        #1;
        chk("B c0 ready", 64'(req_ready_o), 64'b10);
        step();
        req_valid_i = 2'b01;
        #1;
        chk("B c1 ready", 64'(req_ready_o), 64'b00);
        step();
        unit_ready_i = 1'b1;
        #1;
        chk("B c2 ready", 64'(req_ready_o), 64'b01);
        chk("B c2 tag", 64'(unit_data_o.trans_id), 64'd1);
        chk("B c2 op", 64'(unit_data_o.operator), 64'(DIV));
        step();
        req_valid_i = 2'b00;
        d_v = 1'b1; d_t = 2'd1; d_r = 32'd20;
        #1;
        chk("B c3 res_valid", 64'(res_valid_o), 64'b10);
        chk_res("B c3 req1", 1, 32'd81, 2'd0);
        step();
        d_v = 1'b0;
        chk_res("B c4 req0", 0, 32'd20, 2'd1);

        // Out-of-order: DIV tag 0 returns after MUL tag 1.
        do_reset();
        set_req(0, DIV, 32'd7, 32'd1, 2'd2);
        set_req(1, MUL, 32'h5678, 32'd1, 2'd1);
        req_valid_i = 2'b11;
        #1;
        chk("C c0 tag", 64'(unit_data_o.trans_id), 64'd0);
        step();
        req_valid_i = 2'b10;
        #1;
        chk("C c1 tag", 64'(unit_data_o.trans_id), 64'd1);
        step();
        req_valid_i = 2'b00;
        step();
        step();
        chk("C c4 res_valid", 64'(res_valid_o), 64'b10);
        chk_res("C c4 req1", 1, 32'h5678, 2'd1);
        step();
        d_v = 1'b1; d_t = 2'd0; d_r = 32'h1234;
        step();
        d_v = 1'b0;
        chk("C c6 res_valid", 64'(res_valid_o), 64'b01);
        chk_res("C c6 req0", 0, 32'h1234, 2'd2);

        // Credit limit: third MUL stalls until a pop frees space in the same cycle.
        do_reset();
        res_ready_i = 2'b10;
        set_req(0, MUL, 32'd2, 32'd3, 2'd1);
        req_valid_i = 2'b01;
        #1;
        chk("D c0 tag", 64'(unit_data_o.trans_id), 64'd0);
        step();
        set_req(0, MUL, 32'd4, 32'd5, 2'd2);
        #1;
        chk("D c1 ready", 64'(req_ready_o), 64'b01);
        chk("D c1 tag", 64'(unit_data_o.trans_id), 64'd1);
        step();
        set_req(0, MUL, 32'd7, 32'd7, 2'd3);
        #1;
        chk("D c2 ready", 64'(req_ready_o), 64'b00);
        step();
        chk("D c3 ready", 64'(req_ready_o), 64'b00);
        chk_res("D c3 head", 0, 32'd6, 2'd1);
        step();
        chk("D c4 ready stalled", 64'(req_ready_o), 64'b00);
        res_ready_i = 2'b11;
        #1;
        chk("D c4 ready popped", 64'(req_ready_o), 64'b01);
        chk("D c4 tag", 64'(unit_data_o.trans_id), 64'd0);
        chk_res("D c4 head", 0, 32'd6, 2'd1);
        step();
        req_valid_i = 2'b00;
        #1;
        chk_res("D c5 second", 0, 32'd20, 2'd2);
        step();
        chk("D c6 res_valid", 64'(res_valid_o), 64'b00);
        step();
        chk_res("D c7 third", 0, 32'd49, 2'd3);

        // Flush with three ops in flight; returning MUL in the flush cycle is dropped.
        do_reset();
        set_req(0, DIV, 32'd1, 32'd1, 2'd0);
        set_req(1, MUL, 32'd2, 32'd3, 2'd1);
        req_valid_i = 2'b11;
        #1;
        chk("E c0 ready", 64'(req_ready_o), 64'b01);
        step();
        set_req(0, MUL, 32'd4, 32'd4, 2'd2);
        #1;
        chk("E c1 ready", 64'(req_ready_o), 64'b10);
        step();
        req_valid_i = 2'b01;
        #1;
        chk("E c2 tag", 64'(unit_data_o.trans_id), 64'd2);
        step();
        flush_i = 1'b1;
        #1;
        chk("E c3 uflush", 64'(unit_flush_o), 64'd1);
        chk("E c3 ready", 64'(req_ready_o), 64'b00);
        chk("E c3 uvalid", 64'(unit_valid_o), 64'd0);
        step();
        flush_i = 1'b0;
        set_req(0, MUL, 32'd8, 32'd8, 2'd3);
        #1;
        chk("E c4 res_valid", 64'(res_valid_o), 64'b00);
        chk("E c4 ready", 64'(req_ready_o), 64'b01);
        chk("E c4 tag", 64'(unit_data_o.trans_id), 64'd0);
        step();
        req_valid_i = 2'b00;
        #1;
        chk("E c5 res_valid", 64'(res_valid_o), 64'b00);
        step();
        chk("E c6 res_valid", 64'(res_valid_o), 64'b00);
        step();
        chk_res("E c7 req0", 0, 32'd64, 2'd3);

        // Reset in the middle of a DIV.
        do_reset();
        set_req(0, DIV, 32'd9, 32'd3, 2'd1);
        req_valid_i = 2'b01;
        #1;
        chk("F c0 ready", 64'(req_ready_o), 64'b01);
        step();
        req_valid_i = 2'b00;
        rst_i = 1'b1;
        #1;
        chk("F rst uflush", 64'(unit_flush_o), 64'd1);
        step();
        rst_i = 1'b0;
        #1;
        chk("F post res_valid", 64'(res_valid_o), 64'd0);
        chk("F post uvalid", 64'(unit_valid_o), 64'd0);
        chk("F post uflush", 64'(unit_flush_o), 64'd0);
        chk("F post res_o", 64'(res_o), 64'd0);
        set_req(0, MUL, 32'd2, 32'd2, 2'd2);
        req_valid_i = 2'b01;
        #1;
        chk("F new ready", 64'(req_ready_o), 64'b01);
        chk("F new tag", 64'(unit_data_o.trans_id), 64'd0);
        step();
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
